// File: rtl/mem_pkg.sv
// Shared defaults for the single-port word memory, its bus interface and bench.
package mem_pkg;
    localparam int MEM_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH = 4;
    localparam int MEM_DEPTH      = 16;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;
endpackage

// File: rtl/mem_intf.sv
// Request/response bundle for the memory block.
interface mem_intf
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input logic clk_i
);
    logic                  rst_i;
    logic [WIDTH-1:0]      wdata;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_rd;
    logic                  valid;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;

    modport dut (input clk_i, rst_i, wdata, addr, wr_rd, valid, output rdata, ready);
    modport tb  (input clk_i, rdata, ready, output rst_i, wdata, addr, wr_rd, valid);
endinterface

// File: rtl/memory.sv
// Single-port register-array memory: one request per cycle, 1-cycle registered read.
// Out-of-range addresses drop writes and read back as zero.
module memory
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DEPTH      = MEM_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wr_rd_en_i,
    input  logic                  valid_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  ready_o
);
    generate
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("memory: DEPTH must be in 1 .. 2**ADDR_WIDTH");
        end
    endgenerate

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;
    logic             xfer;

    assign in_range = {1'b0, addr_i} < DEPTH_W;
    assign xfer     = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_o <= 1'b0;
            rdata_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_o <= 1'b1;
            if (xfer) begin
                if (wr_rd_en_i == OP_WRITE) begin
                    if (in_range) begin
                        mem[addr_i] <= wdata_i;
                    end
                end else begin
                    rdata_o <= in_range ? mem[addr_i] : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory.sv
// Randomized and directed checks of memory against an array-based reference model;
// a second instance with DEPTH=10 exercises out-of-range addresses.
module tb_memory;
    import mem_pkg::*;

    localparam int DEPTH2 = 10;

    logic clk;
    int   checks;
    int   passes;

    mem_intf #(.WIDTH(MEM_WIDTH), .ADDR_WIDTH(MEM_ADDR_WIDTH)) bus (.clk_i(clk));

    logic [MEM_WIDTH-1:0] rdata2;
    logic                 ready2;

    memory #(.WIDTH(MEM_WIDTH), .ADDR_WIDTH(MEM_ADDR_WIDTH), .DEPTH(MEM_DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (bus.rst_i),
        .wdata_i    (bus.wdata),
        .addr_i     (bus.addr),
        .wr_rd_en_i (bus.wr_rd),
        .valid_i    (bus.valid),
        .rdata_o    (bus.rdata),
        .ready_o    (bus.ready)
    );

    memory #(.WIDTH(MEM_WIDTH), .ADDR_WIDTH(MEM_ADDR_WIDTH), .DEPTH(DEPTH2)) dut2 (
        .clk_i      (clk),
        .rst_i      (bus.rst_i),
        .wdata_i    (bus.wdata),
        .addr_i     (bus.addr),
        .wr_rd_en_i (bus.wr_rd),
        .valid_i    (bus.valid),
        .rdata_o    (rdata2),
        .ready_o    (ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays plus the expected outputs.
    logic [15:0] ref_mem  [MEM_DEPTH];
    logic [15:0] ref_mem2 [DEPTH2];
    logic [15:0] exp_rdata, exp_rdata2;
    logic        exp_ready;

    // Drive one request (inputs set at negedge), advance the model at posedge,
    // return at the next negedge where outputs are sampled.
    task automatic step(input logic v, input logic wr, input int a, input logic [15:0] d);
        bus.valid = v;
        bus.wr_rd = wr;
        bus.addr  = 4'(a);
        bus.wdata = d;
        @(posedge clk);
        if (bus.rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 16'h0;
            for (int i = 0; i < DEPTH2; i++) ref_mem2[i] = 16'h0;
            exp_rdata  = 16'h0;
            exp_rdata2 = 16'h0;
            exp_ready  = 1'b0;
        end else begin
            if (v && exp_ready) begin
                if (wr) begin
                    if (a < MEM_DEPTH) ref_mem[a] = d;
                    if (a < DEPTH2) ref_mem2[a] = d;
                end else begin
                    exp_rdata  = (a < MEM_DEPTH) ? ref_mem[a] : 16'h0;
                    exp_rdata2 = (a < DEPTH2) ? ref_mem2[a] : 16'h0;
                end
            end
            exp_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_reset();
        bus.rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            // A write presented during reset must be discarded.
            step(1'b1, 1'b1, 2, 16'hDEAD);
            checks++;
            if (bus.ready !== 1'b0 || bus.rdata !== 16'h0 || ready2 !== 1'b0 || rdata2 !== 16'h0)
                $display("FAIL reset_hold: ready=%b rdata=%h ready2=%b rdata2=%h want 0/0000", bus.ready, bus.rdata, ready2, rdata2);
            else passes++;
        end
        bus.rst_i = 1'b0;
        // First edge after release: ready rises, but this write is not yet accepted.
        step(1'b1, 1'b1, 1, 16'hBEEF);
        checks++;
        if (bus.ready !== 1'b1 || ready2 !== 1'b1)
            $display("FAIL reset_release_ready: ready=%b ready2=%b want 1", bus.ready, ready2);
        else passes++;
        step(1'b1, 1'b0, 1, 16'h0);
        checks++;
        if (bus.rdata !== 16'h0)
            $display("FAIL first_edge_write_dropped: rdata=%h want 0000", bus.rdata);
        else passes++;
        step(1'b1, 1'b0, 2, 16'h0);
        checks++;
        if (bus.rdata !== 16'h0)
            $display("FAIL reset_write_dropped: rdata=%h want 0000", bus.rdata);
        else passes++;
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 1, 16'h0);
        step(1'b1, 1'b1, 3, 16'hA5A5);
        checks++;
        if (bus.rdata !== 16'h0)
            $display("FAIL write_keeps_rdata: rdata=%h want 0000", bus.rdata);
        else passes++;
        step(1'b1, 1'b0, 3, 16'h0);
        checks++;
        if (bus.rdata !== 16'hA5A5 || rdata2 !== 16'hA5A5)
            $display("FAIL single_rw: rdata=%h rdata2=%h want a5a5", bus.rdata, rdata2);
        else passes++;
    endtask

    task automatic sweep_writes();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, k, 16'(k) + 16'h100);
    endtask

    task automatic test_sweep();
        sweep_writes();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, k, 16'h0);
            checks++;
            if (bus.rdata !== 16'(k) + 16'h100 || rdata2 !== ((k < DEPTH2) ? 16'(k) + 16'h100 : 16'h0))
                $display("FAIL sweep_read[%0d]: rdata=%h rdata2=%h want %h/%h", k, bus.rdata, rdata2,
                         16'(k) + 16'h100, (k < DEPTH2) ? 16'(k) + 16'h100 : 16'h0);
            else passes++;
        end
    endtask

    task automatic test_overwrite();
        step(1'b1, 1'b1, 7, 16'h1111);
        step(1'b1, 1'b1, 7, 16'h2222);
        step(1'b1, 1'b0, 7, 16'h0);
        checks++;
        if (bus.rdata !== 16'h2222)
            $display("FAIL overwrite: rdata=%h want 2222", bus.rdata);
        else passes++;
    endtask

    task automatic test_idle();
        step(1'b1, 1'b0, 5, 16'h0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 5, 16'hFFFF);
            checks++;
            if (bus.rdata !== 16'h0105)
                $display("FAIL idle_stable: rdata=%h want 0105", bus.rdata);
            else passes++;
        end
        step(1'b0, 1'b0, 9, 16'h0);
        step(1'b1, 1'b0, 5, 16'h0);
        checks++;
        if (bus.rdata !== 16'h0105)
            $display("FAIL idle_no_write: rdata=%h want 0105", bus.rdata);
        else passes++;
    endtask

    task automatic test_oob();
        // Writes beyond DEPTH2 must not alias into the small instance.
        step(1'b1, 1'b1, 12, 16'h7777);
        step(1'b1, 1'b0, 12, 16'h0);
        checks++;
        if (rdata2 !== 16'h0 || bus.rdata !== 16'h7777)
            $display("FAIL oob_read: rdata2=%h want 0000 rdata=%h want 7777", rdata2, bus.rdata);
        else passes++;
        step(1'b1, 1'b0, 2, 16'h0);
        checks++;
        if (rdata2 !== 16'h0102)
            $display("FAIL oob_no_alias: rdata2=%h want 0102", rdata2);
        else passes++;
    endtask

    task automatic test_reset_mid();
        sweep_writes();
        step(1'b1, 1'b0, 9, 16'h0);
        bus.rst_i = 1'b1;
        step(1'b1, 1'b0, 4, 16'h0);
        bus.rst_i = 1'b0;
        checks++;
        if (bus.rdata !== 16'h0 || bus.ready !== 1'b0)
            $display("FAIL reset_mid_rdata: rdata=%h ready=%b want 0000/0", bus.rdata, bus.ready);
        else passes++;
        idle();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, k, 16'h0);
            checks++;
            if (bus.rdata !== 16'h0 || rdata2 !== 16'h0)
                $display("FAIL reset_mid_clear[%0d]: rdata=%h rdata2=%h want 0000", k, bus.rdata, rdata2);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), 16'($urandom));
            checks++;
            if (bus.rdata !== exp_rdata || rdata2 !== exp_rdata2 || bus.ready !== exp_ready || ready2 !== exp_ready)
                $display("FAIL random[%0d]: rdata=%h rdata2=%h ready=%b want %h/%h/%b", c, bus.rdata, rdata2,
                         bus.ready, exp_rdata, exp_rdata2, exp_ready);
            else passes++;
        end
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        exp_ready = 1'b0;
        exp_rdata = 16'h0;
        exp_rdata2 = 16'h0;
        bus.rst_i = 1'b1;
        bus.valid = 1'b0;
        bus.wr_rd = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_sweep();
        test_overwrite();
        test_idle();
        test_oob();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 16, number of storage words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 wdata_i  input  WIDTH  write data.
REQ-007 addr_i  input  ADDR_WIDTH  word address for write or read.
REQ-008 wr_rd_en_i  input  1  1 = write, 0 = read.
REQ-009 valid_i  input  1  request valid.
REQ-010 rdata_o  output  WIDTH  read data, registered.
REQ-011 ready_o  output  1  block can accept a request, registered.

Function
REQ-012 A request SHALL transfer on a rising edge where valid_i=1 and ready_o=1; no request transfers otherwise.
REQ-013 ready_o SHALL be 1 in every cycle after reset deassertion; the block accepts one request per cycle and never stalls.
REQ-014 Write transfer (wr_rd_en_i=1): mem[addr_i] <= wdata_i at that edge; rdata_o unchanged.
REQ-015 Read transfer (wr_rd_en_i=0): rdata_o <= mem[addr_i] at that edge, so data is visible the cycle after the request (1-cycle latency).
REQ-016 rdata_o SHALL hold its last read value until the next read transfer or reset.
REQ-017 Back-to-back reads to different addresses SHALL produce their data on consecutive cycles in request order.
REQ-018 Read of an address written in an earlier cycle SHALL return the newest value (write-then-read, no hazard).
REQ-019 Requests are single-port; read and write cannot occur together; wr_rd_en_i selects exactly one.
REQ-020 Address addr_i >= DEPTH: write SHALL be ignored; read SHALL return all zeros.
REQ-021 When valid_i=0, wdata_i, addr_i and wr_rd_en_i SHALL be ignored and no state changes.
REQ-022 Addresses SHALL be used unsigned; no wrap-around or modulo mapping.

Reset
REQ-023 While rst_i=1 at a rising edge: all DEPTH locations cleared to 0, rdata_o <= 0, ready_o <= 0.
REQ-024 Requests presented while rst_i=1 SHALL be discarded; reset overrides any transfer in the same cycle.
REQ-025 The first rising edge with rst_i=0 SHALL set ready_o=1; the first transfer can occur on the following edge.
REQ-026 Reset asserted mid-operation SHALL discard any pending read result; rdata_o SHALL read 0 after that edge.

Structure
REQ-027 WIDTH, ADDR_WIDTH and DEPTH default constants SHALL live in shared package mem_pkg, used by the DUT, by interface mem_intf (clk_i, rst_i, wdata, addr, wr_rd, valid, rdata, ready) and by the bench.
REQ-028 The design SHALL be a single module with an inline register array; no sub-module.
REQ-029 An elaboration-time check SHALL reject DEPTH > 2**ADDR_WIDTH or DEPTH < 1.

Verification
REQ-030 Reset: hold rst_i=1 for 2 cycles -> ready_o=0 and rdata_o=0; after release, ready_o=1 one edge later.
REQ-031 Single write then read: write 16'hA5A5 to addr 3, then read addr 3 -> rdata_o=16'hA5A5 one cycle after the read.
REQ-032 Full sweep: write addr k with data k+16'h100 for k=0..15, then read all 16 back-to-back -> data matches in order on consecutive cycles.
REQ-033 Overwrite: write 16'h1111 then 16'h2222 to addr 7, read addr 7 -> 16'h2222.
REQ-034 Idle: valid_i=0 with wr_rd_en_i=1, addr 5, data 16'hFFFF -> a later read of addr 5 returns its prior value; rdata_o is stable during idle.
REQ-035 Reset mid-run: after the REQ-032 writes, assert rst_i for 1 cycle, then read addr 0..15 -> all zeros.
